// File: rtl/quad_decoder_pkg.sv
// rtl/quad_decoder_pkg.sv - Gray state, direction enum and transition decode for quad_decoder
package quad_decoder_pkg;

  typedef logic [1:0] gray_t;

  localparam gray_t S00 = 2'b00;
  localparam gray_t S01 = 2'b01;
  localparam gray_t S11 = 2'b11;
  localparam gray_t S10 = 2'b10;

  typedef enum logic [1:0] {FWD, REV, NONE, ILLEGAL} dir_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; both bits flipping is a lost step.
  function automatic dir_t decode_transition(gray_t prev, gray_t cur);
    dir_t d;
    if (prev == cur) begin
      d = NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      d = ILLEGAL;
    end else begin
      case ({prev, cur})
        {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: d = FWD;
        default:                                        d = REV;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/quad_decoder_debouncer.sv
// rtl/quad_decoder_debouncer.sv - two-flop synchronizer plus stable-count debounce for one encoder pin
module quad_decoder_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level
);

  logic       sync1;
  logic       sync2;
  logic [7:0] cnt;

  // The level flips on the edge that would bring the count to DEBOUNCE_CYCLES.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == 8'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder top with modular position; QDEC_FULL_STEP_EN selects full-step detent mode
module quad_decoder
  import quad_decoder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_MODULE      = 16,
  parameter int STEP            = 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          enc_a,
  input  logic                          enc_b,
  input  logic                          zero,
  output logic                          step_pulse,
  output logic                          reverse,
  output logic                          err,
  output logic [$clog2(CNT_MODULE)-1:0] pos
);

  localparam int PW = $clog2(CNT_MODULE);
  localparam int SW = PW + 1;
  localparam logic [SW-1:0] STEP_W = SW'(STEP);
  localparam logic [SW-1:0] MOD_W  = SW'(CNT_MODULE);
  localparam logic [SW-1:0] BACK_W = SW'(CNT_MODULE - STEP);

  logic    lvl_a;
  logic    lvl_b;
  gray_t   cur;
  gray_t   prev;
  dir_t    dir;
  logic    step_ev;
  logic [SW-1:0] sum;

  quad_decoder_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk(clk), .reset_n(reset_n), .pin(enc_a), .level(lvl_a)
  );

  quad_decoder_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk(clk), .reset_n(reset_n), .pin(enc_b), .level(lvl_b)
  );

  assign cur = {lvl_a, lvl_b};
  assign dir = decode_transition(prev, cur);

`ifdef QDEC_FULL_STEP_EN
  logic signed [2:0] q;
  logic signed [2:0] q_next;
  logic signed [3:0] q_sum;

  // q only ever holds -3..3; the +-4 that marks a full detent is seen in the wider sum.
  always_comb begin
    q_sum   = {q[2], q};
    q_next  = q;
    step_ev = 1'b0;
    if (dir == FWD) begin
      q_sum = q_sum + 4'sd1;
    end else if (dir == REV) begin
      q_sum = q_sum - 4'sd1;
    end
    if (dir == ILLEGAL) begin
      q_next = '0;
    end else if (dir == FWD || dir == REV) begin
      if (cur == S00) begin
        q_next  = '0;
        step_ev = (q_sum == 4'b0100) || (q_sum == 4'b1100);
      end else begin
        q_next = q_sum[2:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end
`else
  assign step_ev = (dir == FWD) || (dir == REV);
`endif

  always_comb begin
    sum = {1'b0, pos};
    if (dir == FWD) begin
      sum = {1'b0, pos} + STEP_W;
      if (sum >= MOD_W) begin
        sum = sum - MOD_W;
      end
    end else if (STEP_W > {1'b0, pos}) begin
      sum = {1'b0, pos} + BACK_W;
    end else begin
      sum = {1'b0, pos} - STEP_W;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev       <= S00;
      step_pulse <= 1'b0;
      reverse    <= 1'b0;
      err        <= 1'b0;
      pos        <= '0;
    end else begin
      prev       <= cur;
      step_pulse <= step_ev;
      err        <= (dir == ILLEGAL);
      if (step_ev) begin
        reverse <= (dir == REV);
      end
      // zero wins over a simultaneous step; the step still pulses and sets reverse
      if (zero) begin
        pos <= '0;
      end else if (step_ev) begin
        pos <= sum[PW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - randomized and directed self-checking bench for quad_decoder against a per-edge reference model
module tb_quad_decoder;

  localparam int D    = 4;
  localparam int M    = 16;
  localparam int ST   = 1;
  localparam int MAXT = 8000;
`ifdef QDEC_FULL_STEP_EN
  localparam bit FULL = 1'b1;
`else
  localparam bit FULL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enc_a = 1'b0;
  logic       enc_b = 1'b0;
  logic       zero = 1'b0;
  logic       step_pulse;
  logic       reverse;
  logic       err;
  logic [3:0] pos;

  quad_decoder #(.DEBOUNCE_CYCLES(D), .CNT_MODULE(M), .STEP(ST)) dut (
    .clk(clk), .reset_n(reset_n), .enc_a(enc_a), .enc_b(enc_b), .zero(zero),
    .step_pulse(step_pulse), .reverse(reverse), .err(err), .pos(pos)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int t = 0;
  bit ca = 1'b0, cb = 1'b0;
  int last_a = -100, last_b = -100;

  bit ha[MAXT], hb[MAXT], hz[MAXT];
  bit la[MAXT], lb[MAXT];
  bit es[MAXT], ee[MAXT], er[MAXT];
  logic [3:0] ep[MAXT];
  logic os[MAXT], oe[MAXT], orv[MAXT];
  logic [3:0] op[MAXT];
  int m_pos = 0, m_q = 0;
  bit m_rev = 1'b0;

  function automatic bit smp(input bit isb, input int s);
    if (s < 0) return 1'b0;
    return isb ? hb[s] : ha[s];
  endfunction

  function automatic bit lvl(input bit isb, input int e);
    if (e < 0) return 1'b0;
    return isb ? lb[e] : la[e];
  endfunction

  function automatic int gidx(input bit a, input bit b);
    return a ? (b ? 2 : 3) : (b ? 1 : 0);
  endfunction

  // A pin level is accepted once the last D synchronized samples all disagree with it;
  // the registered outputs then reflect the accepted-state change one edge later.
  function automatic void model_edge(input int e);
    int diff, nxt;
    bit step, old, flip;
    for (int p = 0; p < 2; p++) begin
      old  = lvl(p == 1, e - 1);
      flip = 1'b1;
      for (int s = e - D - 1; s <= e - 2; s++) if (smp(p == 1, s) == old) flip = 1'b0;
      if (p == 0) la[e] = flip ? !old : old;
      else        lb[e] = flip ? !old : old;
    end
    diff = (gidx(lvl(1'b0, e - 1), lvl(1'b1, e - 1)) - gidx(lvl(1'b0, e - 2), lvl(1'b1, e - 2)) + 4) % 4;
    step = 1'b0;
    nxt  = m_pos;
    if (FULL) begin
      if (diff == 2) m_q = 0;
      else if (diff != 0) begin
        m_q += (diff == 1) ? 1 : -1;
        if (gidx(lvl(1'b0, e - 1), lvl(1'b1, e - 1)) == 0) begin
          step = (m_q == 4 || m_q == -4);
          m_q  = 0;
        end
      end
    end else begin
      step = (diff == 1 || diff == 3);
    end
    if (step) begin
      m_rev = (diff == 3);
      nxt   = (diff == 1) ? (m_pos + ST) % M : (m_pos + M - ST) % M;
    end
    if (hz[e]) m_pos = 0;
    else if (step) m_pos = nxt;
    es[e] = step;
    ee[e] = (diff == 2);
    er[e] = m_rev;
    ep[e] = 4'(m_pos);
  endfunction

  task automatic cyc(input bit a, input bit b, input bit z);
    if (t >= MAXT) begin
      $display("FAIL history_overflow: t=%0d limit=%0d", t, MAXT);
      $fatal(1, "history overflow");
    end
    enc_a = a; enc_b = b; zero = z;
    ha[t] = a; hb[t] = b; hz[t] = z;
    model_edge(t);
    @(posedge clk);
    #1;
    os[t] = step_pulse; oe[t] = err; orv[t] = reverse; op[t] = pos;
    t++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) cyc(ca, cb, 1'b0);
  endtask

  task automatic go_idx(input int i);
    bit na, nb;
    na = (i == 2 || i == 3);
    nb = (i == 1 || i == 2);
    if (na != ca) last_a = t;
    if (nb != cb) last_b = t;
    ca = na; cb = nb;
    hold(8);
  endtask

  task automatic fwd_move();
    go_idx((gidx(ca, cb) + 1) % 4);
  endtask

  function automatic int count_hi(input int t0, input int t1, input bit use_err);
    int n = 0;
    for (int k = t0; k < t1; k++) if ((use_err ? oe[k] : os[k]) === 1'b1) n++;
    return n;
  endfunction

  task automatic test_reset(input bit stale);
    int t0;
    if (stale) begin
      enc_a = 1'b1; enc_b = 1'b1;
      @(posedge clk); #1;
    end
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (step_pulse !== 1'b0 || reverse !== 1'b0 || err !== 1'b0 || pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: step=%0b rev=%0b err=%0b pos=%0d, want all 0", step_pulse, reverse, err, pos);
    end
    enc_a = 1'b0; enc_b = 1'b0; zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (step_pulse !== 1'b0 || reverse !== 1'b0 || err !== 1'b0 || pos !== 4'd0) begin
      errors++;
      $display("FAIL reset_held: step=%0b rev=%0b err=%0b pos=%0d, want all 0", step_pulse, reverse, err, pos);
    end
    reset_n = 1'b1;
    t = 0; m_pos = 0; m_q = 0; m_rev = 1'b0;
    ca = 1'b0; cb = 1'b0; last_a = -100; last_b = -100;
    t0 = t;
    hold(20);
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL reset_idle edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
    checks++;
    if (count_hi(t0, t, 1'b0) != 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got %0d pulses, want 0", count_hi(t0, t, 1'b0));
    end
  endtask

  task automatic test_forward_wrap();
    int t0, first_hit, first_ev;
    int chg[17];
    t0 = t;
    for (int i = 0; i < 17; i++) begin
      chg[i] = t;
      fwd_move();
    end
    hold(4);
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL fwd_wrap edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
    checks++;
    if (count_hi(t0, t, 1'b0) != (FULL ? 4 : 17)) begin
      errors++;
      $display("FAIL fwd_wrap_count: got %0d pulses, want %0d", count_hi(t0, t, 1'b0), FULL ? 4 : 17);
    end
    first_ev  = chg[FULL ? 3 : 0] + D + 2;
    first_hit = -1;
    for (int k = t0; k < t; k++) if (os[k] === 1'b1 && first_hit < 0) first_hit = k;
    checks++;
    if (first_hit != first_ev) begin
      errors++;
      $display("FAIL fwd_latency: first pulse at edge %0d, want %0d", first_hit, first_ev);
    end
    checks++;
    if (op[t-1] !== (FULL ? 4'd4 : 4'd1)) begin
      errors++;
      $display("FAIL fwd_final_pos: got %0d, want %0d", op[t-1], FULL ? 4 : 1);
    end
  endtask

  task automatic test_backward_wrap();
    int t0, t1;
    t0 = t;
    go_idx(0);
    t1 = t;
    go_idx(3);
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL bwd_wrap edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
    checks++;
    if (count_hi(t1, t, 1'b0) != (FULL ? 0 : 1)) begin
      errors++;
      $display("FAIL bwd_pulse_count: got %0d high cycles, want %0d", count_hi(t1, t, 1'b0), FULL ? 0 : 1);
    end
    checks++;
    if (op[t-1] !== (FULL ? 4'd4 : 4'd15) || orv[t-1] !== ~FULL) begin
      errors++;
      $display("FAIL bwd_pos_rev: got pos=%0d rev=%0b, want pos=%0d rev=%0b", op[t-1], orv[t-1], FULL ? 4 : 15, ~FULL);
    end
    go_idx(0);
  endtask

  task automatic test_glitch();
    int t0, t1;
    t0 = t;
    for (int i = 0; i < 3; i++) cyc(1'b1, cb, 1'b0);
    hold(10);
    checks++;
    if (count_hi(t0, t, 1'b0) != 0) begin
      errors++;
      $display("FAIL glitch_3: got %0d pulses, want 0", count_hi(t0, t, 1'b0));
    end
    t1 = t;
    for (int i = 0; i < 4; i++) cyc(1'b1, cb, 1'b0);
    hold(12);
    checks++;
    if (count_hi(t1, t1 + D + 6, 1'b0) != (FULL ? 0 : 1)) begin
      errors++;
      $display("FAIL glitch_4: got %0d pulses, want %0d", count_hi(t1, t1 + D + 6, 1'b0), FULL ? 0 : 1);
    end
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL glitch edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
  endtask

  task automatic test_illegal();
    int t0, t1;
    t0 = t;
    go_idx(2);
    checks++;
    if (count_hi(t0, t, 1'b1) != 1 || count_hi(t0, t, 1'b0) != 0) begin
      errors++;
      $display("FAIL illegal_err: got err cycles=%0d pulses=%0d, want 1 and 0", count_hi(t0, t, 1'b1), count_hi(t0, t, 1'b0));
    end
    t1 = t;
    go_idx(3);
    checks++;
    if (count_hi(t1, t, 1'b0) != (FULL ? 0 : 1) || orv[t-1] !== 1'b0) begin
      errors++;
      $display("FAIL illegal_recover: got pulses=%0d rev=%0b, want %0d and 0", count_hi(t1, t, 1'b0), orv[t-1], FULL ? 0 : 1);
    end
    go_idx(0);
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL illegal edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
  endtask

  task automatic test_zero_priority();
    int t0, s;
    t0 = t;
    for (int i = 0; i < 3; i++) fwd_move();
    s  = t;
    ca = 1'b0; cb = 1'b0; last_a = t;
    for (int i = 0; i < 8; i++) cyc(ca, cb, i == D + 2);
    checks++;
    if (os[s+D+2] !== 1'b1 || op[s+D+2] !== 4'd0) begin
      errors++;
      $display("FAIL zero_priority: got step=%0b pos=%0d, want step=1 pos=0", os[s+D+2], op[s+D+2]);
    end
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL zero edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
  endtask

  task automatic test_full_step();
    int t0, t1;
    t0 = t;
    for (int i = 0; i < 4; i++) fwd_move();
    checks++;
    if (count_hi(t0, t, 1'b0) != (FULL ? 1 : 4)) begin
      errors++;
      $display("FAIL full_cycle: got %0d pulses, want %0d", count_hi(t0, t, 1'b0), FULL ? 1 : 4);
    end
    t1 = t;
    go_idx(1);
    go_idx(0);
    checks++;
    if (count_hi(t1, t, 1'b0) != (FULL ? 0 : 2)) begin
      errors++;
      $display("FAIL partial_return: got %0d pulses, want %0d", count_hi(t1, t, 1'b0), FULL ? 0 : 2);
    end
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL full_step edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
  endtask

  task automatic test_random();
    int t0, kind, gap, g;
    bit na, nb;
    t0 = t;
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      na = ca; nb = cb;
      if (kind == 0) begin na = !ca; nb = !cb; end
      else if (kind < 5) na = !ca;
      else nb = !cb;
      while ((na != ca && t - last_a < D) || (nb != cb && t - last_b < D)) cyc(ca, cb, 1'b0);
      if (na != ca) last_a = t;
      if (nb != cb) last_b = t;
      ca = na; cb = nb;
      gap = $urandom_range(1, 8);
      for (int i = 0; i < gap; i++) cyc(ca, cb, $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 5) == 0 && t - last_a >= D) begin
        g = $urandom_range(1, D - 1);
        for (int i = 0; i < g; i++) cyc(!ca, cb, 1'b0);
        cyc(ca, cb, 1'b0);
      end
    end
    hold(12);
    for (int k = t0; k < t; k++) begin
      checks++;
      if (os[k] !== es[k] || oe[k] !== ee[k] || orv[k] !== er[k] || op[k] !== ep[k]) begin
        errors++;
        $display("FAIL random edge %0d: got step=%0b err=%0b rev=%0b pos=%0d, want step=%0b err=%0b rev=%0b pos=%0d",
                 k, os[k], oe[k], orv[k], op[k], es[k], ee[k], er[k], ep[k]);
      end
    end
  endtask

  initial begin
    test_reset(1'b0);
    test_forward_wrap();
    test_backward_wrap();
    test_glitch();
    test_illegal();
    test_zero_priority();
    test_full_step();
    test_random();
    test_reset(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature (rotary-encoder) input decoder for the LED controller. It takes the two raw encoder pins, synchronizes and debounces them, and decodes the Gray-code sequence into single-cycle step pulses with a direction flag. It also keeps its own modular position count. The step/reverse outputs drive the same step/reverse semantics used by the controller's modular counters, so this block is the input end of that interface.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required before a pin level is accepted; legal range 1..255.
- `CNT_MODULE`, default 16: modulus of `pos`; must be ≥ 2.
- `STEP`, default 1: amount added to or subtracted from `pos` per decoded step; must satisfy 1 ≤ STEP < CNT_MODULE.
- `clk`, input, 1 bit: the single clock; all logic is on its rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `enc_a`, input, 1 bit: raw encoder channel A, asynchronous to `clk`.
- `enc_b`, input, 1 bit: raw encoder channel B, asynchronous to `clk`.
- `zero`, input, 1 bit: synchronous clear of `pos`.
- `step_pulse`, output, 1 bit: one-cycle pulse per decoded step.
- `reverse`, output, 1 bit: direction of the step that produced the last pulse; 0 = forward, 1 = backward.
- `err`, output, 1 bit: one-cycle pulse on an illegal (double) transition.
- `pos`, output, $clog2(CNT_MODULE) bits: current position, 0..CNT_MODULE-1.

## Operation
- **Reset.** While `reset_n`=0: `step_pulse`=0, `reverse`=0, `err`=0, `pos`=0.
  - Synchronizer flops, debounced levels and the previous state `prev` are all set to 00.
  - Debounce counters and the quarter accumulator `q` are set to 0.
- **Synchronizer.** Each pin passes through a 2-flop synchronizer.
- **Debounce (per channel).**
  - A counter increments on every cycle where the synchronized level differs from the debounced level.
  - The counter clears whenever the two are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, the debounced level takes the synchronized value and the counter clears.
- **Decode.** The state is {A,B} (debounced). The forward sequence is 00→01→11→10→00; the backward sequence is its reverse.
  - One-position move, forward or backward: a legal quarter step.
  - 00↔11 or 01↔10: illegal. Assert `err` for one cycle, emit no step, load `prev` with the new state, clear `q`.
  - No change: no action.
- **Quarter mode (macro absent).** Every legal quarter step produces a step event.
- **Step event.**
  - `step_pulse`=1 for exactly one cycle.
  - `reverse` is set to the direction and holds until the next step event.
  - `pos` updates on the same edge.
- **Position arithmetic.**
  - Forward: `pos` ← (`pos`+STEP) mod CNT_MODULE.
  - Backward: if STEP > `pos`, then `pos` ← CNT_MODULE+`pos`−STEP; otherwise `pos` ← `pos`−STEP.
  - Compute the intermediate sum one bit wider than `pos`.
- **Zero.** `zero`=1 sets `pos`=0 on the next edge.
  - It takes priority over a step event in the same cycle; the step still pulses `step_pulse` and updates `reverse`.
- **Reset mid-operation.** Return to the reset state immediately. Stale synchronizer contents must not generate a step after release.

## Timing
- **Latency.** A pin edge that is stable from sampling edge N produces `step_pulse` high after edge N+DEBOUNCE_CYCLES+2.
  - With the default DEBOUNCE_CYCLES=4 this is 6 edges of latency.
- **Glitches.** A pin pulse shorter than DEBOUNCE_CYCLES cycles produces no event.
- **Back-to-back events.** If A and B are accepted on different edges, each acceptance is decoded independently.
  - One event per cycle at most.
  - Back-to-back events on consecutive cycles are legal.
- **Illegal detection.** `err` arises only when both debounced levels change on the same edge.
- **Registered outputs.** All outputs are registered; there is no combinational path from input to output.

## Configuration
- **Macro `QDEC_FULL_STEP_EN` defined (full-step detent mode).**
  - Legal quarter steps add ±1 to a signed 3-bit accumulator `q`.
  - A step event occurs only when the new state is 00 and `q` reaches +4 (forward) or −4 (backward).
  - `q` clears whenever the state reaches 00, whether or not a step event occurs. A partial rotation that returns therefore produces nothing.
  - Result: one pulse per full detent cycle.
- **Macro absent.** Quarter mode: four pulses per full cycle, and `q` logic is not built.

## Structure
- **Package `quad_decoder_pkg`:**
  - A 2-bit Gray state typedef with named constants S00/S01/S11/S10.
  - A direction enum (FWD/REV/NONE/ILLEGAL).
  - A `decode_transition(prev, cur)` function.
- **Sub-module `debouncer`:** synchronizer plus debounce counter, parameterized by `DEBOUNCE_CYCLES`. Instantiate it once per channel.

## Test plan
All scenarios use the defaults (DEBOUNCE_CYCLES=4, CNT_MODULE=16, STEP=1) and hold each pin level for 8 cycles unless stated otherwise.
- **Reset.** Hold `reset_n` low 3 cycles, then release with pins at 00 → `pos`=0, `step_pulse`=0, `err`=0, `reverse`=0, and no pulses in the following 20 cycles.
- **Forward wrap.** Apply 17 forward quarter steps in quarter mode → 17 pulses, each with `reverse`=0; `pos` goes 1…15, 0, 1 and ends at 1. Check the 6-edge latency on the first pulse.
- **Backward wrap.** From `pos`=0, one backward step (00→10) → `pos`=15, `reverse`=1, a single one-cycle pulse.
- **Glitch rejection.** Pulse `enc_a` high for 3 cycles → no `step_pulse`, `pos` unchanged. Hold it high for 4 cycles → exactly one pulse.
- **Illegal transition.** Drive A and B 00→11 simultaneously → `err` high 1 cycle, no step, `pos` unchanged; a subsequent 11→10 is decoded as a legal forward step.
- **Zero priority and full-step mode.**
  - Assert `zero` in the same cycle as a step event → `pos`=0 and `step_pulse`=1.
  - With `QDEC_FULL_STEP_EN`: one full forward cycle → exactly one pulse.
  - With `QDEC_FULL_STEP_EN`: 00→01→00 → no pulse.
